// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input sample in, INTERP filtered samples out.
// Latency: first y_out_wr_en PHASE_TAPS+1 cycles after x_in_rd_en; PHASE_TAPS+1 cycles per output.
// Backpressure: y_out_full holds S_WRITE with y_out stable; no input is read until all phases are written.
// Optional build macro FIR_INTERP_GAIN_EN: gain of INTERP after requantisation, saturating.
module fir_interp #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int INTERP     = 8,
    parameter logic [TAPS*DATA_WIDTH-1:0] COEFF = {
        -32'sd3,   -32'sd6,   -32'sd12,  -32'sd19,  -32'sd27,  -32'sd33,  -32'sd30,  -32'sd13,
         32'sd21,   32'sd78,   32'sd158,  32'sd254,  32'sd356,  32'sd450,  32'sd524,  32'sd579,
         32'sd579,  32'sd524,  32'sd450,  32'sd356,  32'sd254,  32'sd158,  32'sd78,   32'sd21,
        -32'sd13,  -32'sd30,  -32'sd33,  -32'sd27,  -32'sd19,  -32'sd12,  -32'sd6,   -32'sd3
    }
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  x_in_empty,
    output logic                  x_in_rd_en,
    output logic [DATA_WIDTH-1:0] y_out,
    input  logic                  y_out_full,
    output logic                  y_out_wr_en
);

    localparam int PHASE_TAPS = TAPS / INTERP;
    localparam int PW = $clog2(INTERP);
    localparam int KW = (PHASE_TAPS > 1) ? $clog2(PHASE_TAPS) : 1;
    localparam int IW = $clog2(TAPS);
    localparam int AW = 2 * DATA_WIDTH;
    localparam int GW = AW + PW;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE} state_t;

    state_t state, state_n;
    logic   run_en;
    logic [PW-1:0] phase;
    logic [KW-1:0] k;
    logic [IW-1:0] idx;
    logic signed [AW-1:0] acc, prod, acc_sum;
    logic signed [DATA_WIDTH-1:0] h  [TAPS];
    logic signed [DATA_WIDTH-1:0] sr [PHASE_TAPS];

    for (genvar i = 0; i < TAPS; i++) begin : g_coef
        assign h[i] = COEFF[(TAPS-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Branch p uses taps p, p+L, p+2L, ... against x[n], x[n-1], ...
    assign idx     = IW'(k) * IW'(INTERP) + IW'(phase);
    assign prod    = AW'(h[idx]) * AW'(sr[k]);
    assign acc_sum = acc + prod;

    // Divide by 1024 rounding toward zero, then optional gain with saturation.
    function automatic logic [DATA_WIDTH-1:0] dq(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] q;
        q = (a + ((a < 0) ? AW'(1023) : AW'(0))) >>> 10;
`ifdef FIR_INTERP_GAIN_EN
        begin
            logic signed [GW-1:0] g;
            logic signed [GW-1:0] max_v;
            logic signed [GW-1:0] min_v;
            max_v = GW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
            min_v = -max_v - GW'(1);
            g = GW'(q) <<< PW;
            if (g > max_v)
                g = max_v;
            else if (g < min_v)
                g = min_v;
            return g[DATA_WIDTH-1:0];
        end
`else
        return q[DATA_WIDTH-1:0];
`endif
    endfunction

    always_comb begin
        state_n     = state;
        x_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        case (state)
            S_IDLE: begin
                // run_en keeps the pop low through reset and its release cycle
                if (run_en && !x_in_empty) begin
                    x_in_rd_en = 1'b1;
                    state_n    = S_MAC;
                end
            end
            S_MAC: begin
                if (k == KW'(PHASE_TAPS - 1))
                    state_n = S_WRITE;
            end
            S_WRITE: begin
                if (!y_out_full) begin
                    y_out_wr_en = 1'b1;
                    state_n     = (phase == PW'(INTERP - 1)) ? S_IDLE : S_MAC;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            run_en <= 1'b0;
            phase  <= '0;
            k      <= '0;
            acc    <= '0;
            y_out  <= '0;
            for (int i = 0; i < PHASE_TAPS; i++)
                sr[i] <= '0;
        end else begin
            state  <= state_n;
            run_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (x_in_rd_en) begin
                        sr[0] <= x_in;
                        for (int i = 1; i < PHASE_TAPS; i++)
                            sr[i] <= sr[i-1];
                        acc   <= '0;
                        phase <= '0;
                        k     <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc_sum;
                    if (k == KW'(PHASE_TAPS - 1))
                        y_out <= dq(acc_sum);
                    else
                        k <= k + KW'(1);
                end
                S_WRITE: begin
                    if (y_out_wr_en && phase != PW'(INTERP - 1)) begin
                        phase <= phase + PW'(1);
                        k     <= '0;
                        acc   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp.sv
// Bench for fir_interp: vector table, corner-case sequences and a randomized scoreboard.
module tb_fir_interp;

    localparam int TAPS = 32;
    localparam int L    = 8;
    localparam int PT   = TAPS / L;
`ifdef FIR_INTERP_GAIN_EN
    localparam int G = L;
`else
    localparam int G = 1;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] x_in = '0;
    logic        x_in_empty = 1'b1;
    logic        x_in_rd_en;
    logic [31:0] y_out;
    logic        y_out_full = 1'b0;
    logic        y_out_wr_en;

    always #5 clock = ~clock;

    fir_interp dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .x_in        (x_in),
        .x_in_empty  (x_in_empty),
        .x_in_rd_en  (x_in_rd_en),
        .y_out       (y_out),
        .y_out_full  (y_out_full),
        .y_out_wr_en (y_out_wr_en)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference coefficients h[0..31]
    int h_ref [TAPS] = '{-3, -6, -12, -19, -27, -33, -30, -13,
                         21, 78, 158, 254, 356, 450, 524, 579,
                         579, 524, 450, 356, 254, 158, 78, 21,
                         -13, -30, -33, -27, -19, -12, -6, -3};

    // Behavioural model: input history plus a queue of pending expected outputs
    int hist [PT] = '{default: 0};
    int exp_q [$];

    function automatic int dq_ref(input longint a);
        longint q;
        q = a / 64'sd1024;
`ifdef FIR_INTERP_GAIN_EN
        q = q * L;
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
`endif
        return int'(q);
    endfunction

    task automatic model_push(input int x);
        for (int k = PT - 1; k > 0; k--)
            hist[k] = hist[k-1];
        hist[0] = x;
        for (int p = 0; p < L; p++) begin
            longint a = 0;
            for (int k = 0; k < PT; k++)
                a += longint'(h_ref[p + k*L]) * longint'(hist[k]);
            exp_q.push_back(dq_ref(a));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < PT; k++)
            hist[k] = 0;
        exp_q.delete();
    endtask

    // Upstream FWFT FIFO model and random stall generator
    int src [$];
    bit starve = 1'b0;
    bit rand_mode = 1'b0;

    initial begin
        forever begin
            bit pop;
            @(negedge clock);
            pop = x_in_rd_en;
            @(posedge clock);
            #1;
            if (pop && src.size() > 0)
                model_push(src.pop_front());
            if (rand_mode) begin
                y_out_full = ($urandom_range(0, 3) == 0);
                starve     = ($urandom_range(0, 4) == 0);
            end
            x_in_empty = (src.size() == 0) || starve;
            x_in       = (src.size() > 0) ? src[0] : 32'd0;
        end
    end

    // Output monitor and scoreboard
    int cyc = 0;
    int rd_cyc [$];
    int wr_cyc [$];
    int obs [$];

    always @(negedge clock) begin
        cyc++;
        if (reset_n) begin
            if (x_in_rd_en) begin
                check("rd_while_empty", x_in_empty, 0);
                rd_cyc.push_back(cyc);
            end
            if (y_out_wr_en) begin
                check("wr_while_full", y_out_full, 0);
                obs.push_back($signed(y_out));
                wr_cyc.push_back(cyc);
                check("sb_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    check("sb_out", $signed(y_out), exp_q.pop_front());
            end
        end
    end

    task automatic wait_obs(input int n, input int budget, input string name);
        int c = 0;
        while (obs.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(name, obs.size(), n);
    endtask

    task automatic drain(input int budget, input string name);
        int c = 0;
        while ((src.size() > 0 || exp_q.size() > 0) && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(name, src.size() + exp_q.size(), 0);
    endtask

    task automatic run_impulse(input string name);
        obs.delete();
        src.push_back(1024);
        repeat (3) src.push_back(0);
        wait_obs(32, 600, {name, "_count"});
        for (int j = 0; j < 32 && j < obs.size(); j++)
            check(name, obs[j], h_ref[j] * G);
    endtask

    function automatic int rand_sample();
        if ($urandom_range(0, 1) == 1)
            return int'($urandom);
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    typedef struct {
        int x;
        int e0;
        int e1;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n_rd, changes, bad, held, first_rd;

        // Impulse then DC: phase 0 and phase 1 outputs of each input
        tbl[0]  = '{1024, -3, -6};
        tbl[1]  = '{0, 21, 78};
        tbl[2]  = '{0, 579, 524};
        tbl[3]  = '{0, -13, -30};
        tbl[4]  = '{1024, -3, -6};
        tbl[5]  = '{1024, 18, 72};
        tbl[6]  = '{1024, 597, 596};
        for (int i = 7; i < 12; i++)
            tbl[i] = '{1024, 584, 566};

        // Reset with a sample waiting upstream: no pop may happen
        src.push_back(0);
        repeat (3) @(negedge clock);
        #1;
        check("reset_empty_seen", x_in_empty, 0);
        check("reset_rd_en", x_in_rd_en, 0);
        check("reset_wr_en", y_out_wr_en, 0);
        check("reset_y_out", $signed(y_out), 0);
        @(negedge clock);
        reset_n = 1'b1;
        drain(200, "drain_init");

        // Table-driven impulse and DC response
        obs.delete();
        for (int i = 0; i < 12; i++)
            src.push_back(tbl[i].x);
        wait_obs(96, 12 * 41 + 200, "table_count");
        for (int i = 0; i < 12 && 8*i + 1 < obs.size(); i++) begin
            check($sformatf("table%0d_p0", i), obs[8*i], tbl[i].e0 * G);
            check($sformatf("table%0d_p1", i), obs[8*i + 1], tbl[i].e1 * G);
        end
        for (int j = 0; j < 32 && j < obs.size(); j++)
            check("impulse_h", obs[j], h_ref[j] * G);

        // Backpressure at the third output of an input
        obs.delete();
        src.push_back(rand_sample());
        src.push_back(rand_sample());
        wait_obs(2, 200, "bp_pre_count");
        @(negedge clock);
        y_out_full = 1'b1;
        n_rd = rd_cyc.size();
        changes = 0;
        held = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (i == 10)
                held = $signed(y_out);
            else if (i > 10 && $signed(y_out) != held)
                changes++;
        end
        check("bp_no_wr", obs.size(), 2);
        check("bp_no_rd", rd_cyc.size(), n_rd);
        check("bp_y_stable", changes, 0);
        check("bp_y_value", held, exp_q.size() > 0 ? exp_q[0] : 32'hdead);
        y_out_full = 1'b0;
        drain(400, "bp_drain");
        check("bp_total", obs.size(), 16);

        // Starvation
        starve = 1'b1;
        obs.delete();
        n_rd = rd_cyc.size();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (x_in_rd_en || y_out_wr_en)
                bad++;
        end
        check("starve_no_activity", bad, 0);
        check("starve_no_rd", rd_cyc.size(), n_rd);
        starve = 1'b0;

        // Back-to-back timing
        rd_cyc.delete();
        wr_cyc.delete();
        for (int i = 0; i < 10; i++)
            src.push_back(rand_sample());
        drain(600, "timing_drain");
        check("timing_rd_count", rd_cyc.size(), 10);
        if (rd_cyc.size() == 10 && wr_cyc.size() > 0) begin
            first_rd = rd_cyc[0];
            for (int i = 1; i < 10; i++)
                check($sformatf("timing_rd_gap%0d", i), rd_cyc[i] - rd_cyc[i-1], 41);
            check("timing_first_wr", wr_cyc[0] - first_rd, 5);
            bad = 0;
            foreach (wr_cyc[i])
                if (wr_cyc[i] >= first_rd && wr_cyc[i] < first_rd + 410)
                    bad++;
            check("timing_wr_in_410", bad, 80);
        end

        // Reset during S_MAC of phase 3 drops the sample and clears history
        obs.delete();
        src.push_back(rand_sample() | 32'h100);
        wait_obs(3, 200, "rst_pre_count");
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rd_en", x_in_rd_en, 0);
        check("midrst_wr_en", y_out_wr_en, 0);
        check("midrst_y_out", $signed(y_out), 0);
        model_reset();
        src.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run_impulse("post_reset_impulse");
        drain(200, "post_reset_drain");

        // Randomized data with random stalls on both sides
        rand_mode = 1'b1;
        for (int i = 0; i < 30; i++)
            src.push_back(rand_sample());
        drain(20000, "rand_drain");
        rand_mode = 1'b0;
        @(negedge clock);
        y_out_full = 1'b0;
        starve = 1'b0;
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
